dit_latency_monitor: RTL
========================

# dit_latency_monitor

Synthesizable runtime monitor that checks the multiply/divide unit completes every operation in a fixed, operator-dependent number of cycles whenever data-independent timing is enabled. It sits beside the vcve2 multdiv block, snooping its enable, operator, valid and ID-stage ready signals. It reports a sticky error with cause and operator, plus the measured latency of every completed operation. It generalises a single fixed-count check to per-operator expected latencies, timeout detection, abort handling and back-to-back operations.

## Interface
- NumOps, 4: number of operators tracked; equals the width of the vcve2_pkg::md_op_e encoding space.
- CntWidth, 6: latency counter width; must hold max(ExpLat)+1.
- ExpLat, {37,37,33,33}: packed array [NumOps-1:0][CntWidth-1:0], indexed by operator (MULL=33, MULH=33, DIV=37, REM=37).
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- mult_en_i  in  1  multiply enable from ID stage.
- div_en_i  in  1  divide enable from ID stage.
- operator_i  in  md_op_e  operator; sampled at start.
- data_ind_timing_i  in  1  check enable; sampled at start.
- valid_i  in  1  multdiv result valid.
- ready_id_i  in  1  ID stage consumes the result.
- clr_i  in  1  synchronous clear of sticky error state.
- err_o  out  1  sticky error flag.
- err_cause_o  out  dit_err_e  first error cause: NONE, EARLY, TIMEOUT.
- err_op_o  out  md_op_e  operator of the first error.
- lat_valid_o  out  1  one-cycle pulse: measured latency published.
- lat_o  out  CntWidth  measured latency of the last completed operation.

## Operation
- en = mult_en_i | div_en_i.
- FSM states: IDLE, BUSY, HOLD.
- IDLE → BUSY when en=1 and valid_i=0. Capture operator_i and data_ind_timing_i. Counter loads 0 in the start cycle.
- IDLE with en=1 and valid_i=1 in the same cycle: latency 0. Publish it; if checking, flag EARLY unless ExpLat[op]==0. Go to HOLD if ready_id_i=0, else stay IDLE.
- BUSY: counter increments by 1 each cycle. Latency equals the number of clock edges between the start cycle and the valid cycle.
- BUSY, valid_i=1:
  - Publish count.
  - If checking and count<ExpLat[op], flag EARLY. A mismatch above ExpLat cannot reach here because the timeout fires first.
  - Next state is HOLD if ready_id_i=0, else IDLE.
- BUSY, count==ExpLat[op] and valid_i=0: flag TIMEOUT if checking. Stay in BUSY and keep counting.
- Counter saturates at all-ones with no wrap. lat_o then equals all-ones.
- BUSY, en=0 and valid_i=0: abort (kill/flush). Return to IDLE with no check and no publish.
- HOLD: wait for ready_id_i=1, then go to IDLE. valid_i may stay high; no re-publish. en dropping in HOLD also returns to IDLE.
- Back-to-back: a start is only recognised in IDLE. An en held high across the completion cycle starts a new operation in the first IDLE cycle.
- Errors:
  - err_cause_o and err_op_o record only the first error.
  - Later errors keep err_o set and leave the cause unchanged.
  - clr_i clears all three outputs; an error flagged in the same cycle as clr_i wins.
- Checking disabled at start: latency is still measured and published, but no errors are raised.

## Timing
- Reset values: state IDLE; counter 0; err_o 0; err_cause_o NONE; err_op_o MD_OP_MULL; lat_valid_o 0; lat_o 0.
- All outputs are registered.
- lat_valid_o and lat_o update the cycle after the valid cycle.
- err_o updates the cycle after the detecting cycle.
- TIMEOUT is reported in cycle ExpLat[op]+1 after start.
- Asynchronous reset mid-operation discards the operation with no error.

## Configuration
- DIT_MON_STATS_EN defined:
  - Adds output max_lat_o (NumOps×CntWidth), the per-operator maximum published latency. Reset value 0; cleared by clr_i.
  - Adds output op_cnt_o (NumOps×16), the per-operator completed-operation count, saturating.
- Undefined: neither port exists and no storage is instantiated.

## Structure
- Package dit_mon_pkg holds:
  - dit_state_e (IDLE, BUSY, HOLD);
  - dit_err_e (NONE, EARLY, TIMEOUT);
  - default latency constants DIT_LAT_MUL=33 and DIT_LAT_DIV=37.
- Reuses vcve2_pkg::md_op_e.
- Optional sub-module dit_mon_stats holds the DIT_MON_STATS_EN storage and is instantiated only under the macro.

## Test plan
- MULL start, checking on, valid 33 edges later, ready=1 → lat_valid_o pulse, lat_o=33, err_o stays 0.
- DIV start, checking on, valid after 20 edges → err_o=1, err_cause_o=EARLY, err_op_o=DIV, lat_o=20.
- REM start, checking on, no valid → err_o rises at cycle 38, err_cause_o=TIMEOUT; a later valid at 40 publishes lat_o=40 and the cause stays TIMEOUT.
- MULH start, en dropped after 10 cycles → no publish, no error, next MULL start measures 33 cleanly.
- Checking off, DIV valid after 5 edges → lat_o=5, err_o=0. Then valid with ready low for 3 cycles → single pulse, HOLD then IDLE.
- Error pending, clr_i pulse → err_o=0, err_cause_o=NONE. Under DIT_MON_STATS_EN, max_lat_o[MULL]=33 after test 1 and is cleared by clr_i.

Source files
------------

// File: rtl/dit_mon_pkg.sv
// Types and default latencies for the data-independent-timing latency monitor.
package dit_mon_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HOLD = 2'd2
    } dit_state_e;

    typedef enum logic [1:0] {
        NONE    = 2'd0,
        EARLY   = 2'd1,
        TIMEOUT = 2'd2
    } dit_err_e;

    localparam int unsigned DIT_LAT_MUL = 33;
    localparam int unsigned DIT_LAT_DIV = 37;

endpackage

// File: rtl/vcve2_pkg.sv
// Multiply/divide operator encoding shared with the vcve2 multdiv unit.
package vcve2_pkg;

    typedef enum logic [1:0] {
        MD_OP_MULL = 2'd0,
        MD_OP_MULH = 2'd1,
        MD_OP_DIV  = 2'd2,
        MD_OP_REM  = 2'd3
    } md_op_e;

endpackage

// File: rtl/dit_latency_monitor_if.sv
// Snoop/report bundle between the multdiv unit and the latency monitor.
interface dit_latency_monitor_if #(
    parameter int unsigned CntWidth = 6
);
    import vcve2_pkg::*;
    import dit_mon_pkg::*;

    logic                mult_en_i;
    logic                div_en_i;
    md_op_e              operator_i;
    logic                data_ind_timing_i;
    logic                valid_i;
    logic                ready_id_i;
    logic                clr_i;
    logic                err_o;
    dit_err_e            err_cause_o;
    md_op_e              err_op_o;
    logic                lat_valid_o;
    logic [CntWidth-1:0] lat_o;

    modport master (
        output mult_en_i, div_en_i, operator_i, data_ind_timing_i, valid_i, ready_id_i, clr_i,
        input  err_o, err_cause_o, err_op_o, lat_valid_o, lat_o
    );

    modport slave (
        input  mult_en_i, div_en_i, operator_i, data_ind_timing_i, valid_i, ready_id_i, clr_i,
        output err_o, err_cause_o, err_op_o, lat_valid_o, lat_o
    );

endinterface

// File: rtl/dit_mon_stats.sv
// Per-operator maximum latency and saturating completion count for the latency monitor.
module dit_mon_stats
    import vcve2_pkg::*;
#(
    parameter int unsigned NumOps   = 4,
    parameter int unsigned CntWidth = 6
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             clr_i,
    input  logic                             pub_i,
    input  md_op_e                           op_i,
    input  logic [CntWidth-1:0]              lat_i,
    output logic [NumOps-1:0][CntWidth-1:0]  max_lat_o,
    output logic [NumOps-1:0][15:0]          op_cnt_o
);

    logic [NumOps-1:0][CntWidth-1:0] r_max_lat;
    logic [NumOps-1:0][15:0]         r_op_cnt;

    // A publish in the clear cycle seeds the fresh maximum.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_max_lat <= '0;
            r_op_cnt  <= '0;
        end else begin
            if (clr_i) begin
                r_max_lat <= '0;
            end
            if (pub_i) begin
                if (clr_i || (lat_i > r_max_lat[op_i])) begin
                    r_max_lat[op_i] <= lat_i;
                end
                if (r_op_cnt[op_i] != 16'hFFFF) begin
                    r_op_cnt[op_i] <= r_op_cnt[op_i] + 16'd1;
                end
            end
        end
    end

    assign max_lat_o = r_max_lat;
    assign op_cnt_o  = r_op_cnt;

endmodule

// File: rtl/dit_latency_monitor.sv
// Runtime check that multdiv operations finish in their fixed per-operator latency.
// Optional per-operator statistics are built when DIT_MON_STATS_EN is defined.
module dit_latency_monitor
    import vcve2_pkg::*;
    import dit_mon_pkg::*;
#(
    parameter int unsigned                      NumOps   = 4,
    parameter int unsigned                      CntWidth = 6,
    parameter logic [NumOps-1:0][CntWidth-1:0]  ExpLat   = {CntWidth'(DIT_LAT_DIV), CntWidth'(DIT_LAT_DIV),
                                                            CntWidth'(DIT_LAT_MUL), CntWidth'(DIT_LAT_MUL)}
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    dit_latency_monitor_if.slave             bus
`ifdef DIT_MON_STATS_EN
    ,
    output logic [NumOps-1:0][CntWidth-1:0]  max_lat_o,
    output logic [NumOps-1:0][15:0]          op_cnt_o
`endif
);

    localparam logic [CntWidth-1:0] CntMax = '1;

    dit_state_e          r_state;
    md_op_e              r_op;
    logic                r_chk;
    logic [CntWidth-1:0] r_cnt;
    logic                r_err;
    dit_err_e            r_err_cause;
    md_op_e              r_err_op;
    logic                r_lat_valid;
    logic [CntWidth-1:0] r_lat;

    logic                w_en;
    logic                w_pub;
    logic [CntWidth-1:0] w_pub_lat;
    logic                w_flag;
    dit_err_e            w_flag_cause;
    md_op_e              w_op;

    assign w_en = bus.mult_en_i | bus.div_en_i;

    // Timeout only while the operation is still alive; an abort skips all checks.
    always_comb begin
        w_pub        = 1'b0;
        w_pub_lat    = r_cnt;
        w_flag       = 1'b0;
        w_flag_cause = NONE;
        w_op         = r_op;
        case (r_state)
            IDLE: begin
                if (w_en && bus.valid_i) begin
                    w_pub     = 1'b1;
                    w_pub_lat = '0;
                    w_op      = bus.operator_i;
                    if (bus.data_ind_timing_i && (ExpLat[bus.operator_i] != '0)) begin
                        w_flag       = 1'b1;
                        w_flag_cause = EARLY;
                    end
                end
            end
            BUSY: begin
                if (bus.valid_i) begin
                    w_pub = 1'b1;
                    if (r_chk && (r_cnt < ExpLat[r_op])) begin
                        w_flag       = 1'b1;
                        w_flag_cause = EARLY;
                    end
                end else if (w_en && r_chk && (r_cnt == ExpLat[r_op])) begin
                    w_flag       = 1'b1;
                    w_flag_cause = TIMEOUT;
                end
            end
            default: ;
        endcase
    end

    // Counter holds the number of edges since the start cycle while BUSY.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
            r_op    <= MD_OP_MULL;
            r_chk   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_en) begin
                        if (bus.valid_i) begin
                            r_state <= bus.ready_id_i ? IDLE : HOLD;
                        end else begin
                            r_state <= BUSY;
                            r_op    <= bus.operator_i;
                            r_chk   <= bus.data_ind_timing_i;
                            r_cnt   <= CntWidth'(1);
                        end
                    end
                end
                BUSY: begin
                    if (bus.valid_i) begin
                        r_state <= bus.ready_id_i ? IDLE : HOLD;
                        r_cnt   <= '0;
                    end else if (!w_en) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt != CntMax) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (bus.ready_id_i || !w_en) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_lat_valid <= 1'b0;
            r_lat       <= '0;
        end else begin
            r_lat_valid <= w_pub;
            if (w_pub) begin
                r_lat <= w_pub_lat;
            end
        end
    end

    // A new error in the clear cycle becomes the recorded first error.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_err       <= 1'b0;
            r_err_cause <= NONE;
            r_err_op    <= MD_OP_MULL;
        end else if (w_flag) begin
            r_err <= 1'b1;
            if (!r_err || bus.clr_i) begin
                r_err_cause <= w_flag_cause;
                r_err_op    <= w_op;
            end
        end else if (bus.clr_i) begin
            r_err       <= 1'b0;
            r_err_cause <= NONE;
            r_err_op    <= MD_OP_MULL;
        end
    end

    assign bus.err_o       = r_err;
    assign bus.err_cause_o = r_err_cause;
    assign bus.err_op_o    = r_err_op;
    assign bus.lat_valid_o = r_lat_valid;
    assign bus.lat_o       = r_lat;

`ifdef DIT_MON_STATS_EN
    dit_mon_stats #(
        .NumOps   (NumOps),
        .CntWidth (CntWidth)
    ) u_stats (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clr_i     (bus.clr_i),
        .pub_i     (w_pub),
        .op_i      (w_op),
        .lat_i     (w_pub_lat),
        .max_lat_o (max_lat_o),
        .op_cnt_o  (op_cnt_o)
    );
`endif

endmodule
